wireless_cmd_tx: RTL and testbench

Transmit-side counterpart of the `sensor` receiver. It serialises command frames onto the `wireless_rx` line (UART 8N1) toward the wireless sensor module and drives `wireless_set` for the module's configuration mode. It sits beside `sensor` under `mod_top` on the 100 MHz `clk_100m` domain. Game/debug logic hands it one command at a time through a valid/ready handshake.

---
 rtl/wireless_pkg.sv | 23 ++
 rtl/wireless_cmd_tx_uart.sv | 78 +++++++
 rtl/wireless_cmd_tx.sv | 178 +++++++++++++++++
 tb/tb_wireless_cmd_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wireless_pkg.sv
// Types and constants shared by the wireless command transmitter and the sensor receiver.
// Payload capacity in cmd_t is a fixed upper bound; instances use MAX_LEN <= CMD_MAX_LEN.
package wireless_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int         CMD_MAX_LEN  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_SETUP,
    ST_SHIFT,
    ST_SET_HOLD,
    ST_DONE
  } tx_state_t;

  typedef struct packed {
    logic                     at_mode;
    logic [7:0]               opcode;
    logic [7:0]               len;
    logic [8*CMD_MAX_LEN-1:0] payload;
  } cmd_t;

endpackage

// File: rtl/wireless_cmd_tx_uart.sv
// 8N1 byte serialiser: start bit on tx the cycle after start&&ready, each bit DIV cycles.
// ready is also high in the last stop-bit cycle so a queued byte follows with no idle gap.
module uart_tx_byte #(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CYC_LAST = CW'(DIV - 1);
  localparam logic [3:0]     BIT_STOP = 4'd9;

  logic          active_q, active_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [8:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          last_cyc;

  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    last_cyc = (cyc_q == CYC_LAST);
    ready    = !active_q || (last_cyc && (bit_q == BIT_STOP));

    if (active_q) begin
      if (last_cyc) begin
        cyc_d = '0;
        if (bit_q == BIT_STOP) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          // sh_q[8] is the stop bit, so it reaches tx after the eight data bits
          bit_d = bit_q + 4'd1;
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
        end
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end

    if (start && ready) begin
      active_d = 1'b1;
      bit_d    = '0;
      cyc_d    = '0;
      tx_d     = 1'b0;
      sh_d     = {1'b1, data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      cyc_q    <= '0;
      sh_q     <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/wireless_cmd_tx.sv
// Command transmitter: framed (A5,op,len,payload,csum) or raw AT bytes with wireless_set low.
// First output the cycle after acceptance; cmd_ready low while busy, high again in the done cycle.
module wireless_cmd_tx
  import wireless_pkg::*;
#(
  parameter int CLK_FREQ         = 100_000_000,
  parameter int BAUD             = 9600,
  parameter int MAX_LEN          = 16,
  parameter int SET_SETUP_CYCLES = 4_000_000,
  parameter int SET_HOLD_CYCLES  = 8_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_at_mode,
  input  logic [7:0]                   cmd_opcode,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [8*MAX_LEN-1:0]         cmd_payload,
  output logic                         busy,
  output logic                         done,
  output logic                         wireless_rx,
  output logic                         wireless_set
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TMAX = (SET_SETUP_CYCLES > SET_HOLD_CYCLES) ? SET_SETUP_CYCLES : SET_HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PBW  = $clog2(8 * CMD_MAX_LEN);

  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_LEN);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SET_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(SET_HOLD_CYCLES - 1);

  tx_state_t     state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          set_q, set_d;

  logic           accept;
  logic [LW-1:0]  len_clamped;
  logic [7:0]     total_bytes;
  logic [7:0]     pay_idx;
  logic [PBW-1:0] pay_bit;
  logic [7:0]     pay_byte;
  logic [7:0]     cur_byte;
  logic           tx_start;
  logic [7:0]     tx_byte;
  logic           tx_ready;

  // Byte at position idx_q of the current sequence.
  always_comb begin
    pay_idx  = cmd_q.at_mode ? idx_q : (idx_q - 8'd3);
    pay_bit  = PBW'({pay_idx, 3'b000});
    pay_byte = cmd_q.payload[pay_bit +: 8];
    if (cmd_q.at_mode)                       cur_byte = pay_byte;
    else if (idx_q == 8'd0)                  cur_byte = FRAME_HEADER;
    else if (idx_q == 8'd1)                  cur_byte = cmd_q.opcode;
    else if (idx_q == 8'd2)                  cur_byte = cmd_q.len;
    else if (idx_q == cmd_q.len + 8'd3)      cur_byte = csum_q;
    else                                     cur_byte = pay_byte;
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    tmr_d       = tmr_q + 1'b1;
    tx_start    = 1'b0;
    tx_byte     = cur_byte;
    accept      = cmd_valid && ready_q;
    len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    total_bytes = cmd_q.at_mode ? cmd_q.len : (cmd_q.len + 8'd4);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          cmd_d.at_mode = cmd_at_mode;
          cmd_d.opcode  = cmd_opcode;
          cmd_d.len     = 8'(len_clamped);
          cmd_d.payload = (8*CMD_MAX_LEN)'(cmd_payload);
          csum_d        = '0;
          tmr_d         = '0;
          if (cmd_at_mode) begin
            idx_d   = '0;
            state_d = ST_SET_SETUP;
          end else begin
            tx_start = 1'b1;
            tx_byte  = FRAME_HEADER;
            idx_d    = 8'd1;
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SET_SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          tmr_d = '0;
          if (cmd_q.len != 8'd0) begin
            tx_start = 1'b1;
            idx_d    = idx_q + 8'd1;
            state_d  = ST_SHIFT;
          end else begin
            state_d = ST_SET_HOLD;
          end
        end
      end
      ST_SHIFT: begin
        // tx_ready here means the last stop-bit cycle: chain the next byte or leave
        if (tx_ready) begin
          if (idx_q < total_bytes) begin
            tx_start = 1'b1;
            idx_d    = idx_q + 8'd1;
            if (!cmd_q.at_mode) csum_d = csum_q + cur_byte;
          end else begin
            tmr_d   = '0;
            state_d = cmd_q.at_mode ? ST_SET_HOLD : ST_DONE;
          end
        end
      end
      ST_SET_HOLD: begin
        if (tmr_q == HOLD_LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_SET_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_SET_HOLD);
    ready_d = !busy_d;
    done_d  = (state_d == ST_DONE);
    set_d   = !(busy_d && cmd_d.at_mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      set_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      tmr_q   <= tmr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      set_q   <= set_d;
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_uart (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_byte),
    .ready (tx_ready),
    .tx    (wireless_rx)
  );

  assign cmd_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wireless_set = set_q;

endmodule

// File: tb/tb_wireless_cmd_tx.sv
// Directed bench for wireless_cmd_tx with DIV=10, MAX_LEN=4, setup 20, hold 30.
module tb_wireless_cmd_tx;

  localparam int LOGN = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_at_mode;
  logic [7:0]  cmd_opcode;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        busy;
  logic        done;
  logic        wireless_rx;
  logic        wireless_set;

  int total = 0;
  int bad   = 0;

  logic rx_log   [0:LOGN-1];
  logic set_log  [0:LOGN-1];
  logic busy_log [0:LOGN-1];
  logic rdy_log  [0:LOGN-1];

  always #5 clk = ~clk;

  wireless_cmd_tx #(
    .CLK_FREQ(1000), .BAUD(100), .MAX_LEN(4),
    .SET_SETUP_CYCLES(20), .SET_HOLD_CYCLES(30)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_at_mode(cmd_at_mode), .cmd_opcode(cmd_opcode),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .busy(busy), .done(done),
    .wireless_rx(wireless_rx), .wireless_set(wireless_set)
  );

  // Decodes one 8N1 byte whose start bit begins at log index base; -1 if malformed.
  function automatic int decode_byte(input int base);
    logic [7:0] d;
    logic       v;
    logic       ok;
    d  = '0;
    ok = (base >= 1) && (base + 99 < LOGN);
    if (ok) begin
      for (int j = 0; j < 10; j++) begin
        v = rx_log[base + j*10];
        for (int s = 1; s < 10; s++)
          if (rx_log[base + j*10 + s] !== v) ok = 1'b0;
        if (j == 0 && v !== 1'b0) ok = 1'b0;
        if (j == 9 && v !== 1'b1) ok = 1'b0;
        if (j >= 1 && j <= 8) d = {v, d[7:1]};
      end
    end
    return ok ? int'(d) : -1;
  endfunction

  task automatic sample(input int k);
    rx_log[k]   = wireless_rx;
    set_log[k]  = wireless_set;
    busy_log[k] = busy;
    rdy_log[k]  = cmd_ready;
  endtask

  // Offers one command, scrambles inputs after acceptance, logs until done (-1 if none).
  task automatic run_cmd(input logic at, input logic [7:0] op, input logic [2:0] len,
                         input logic [31:0] pl, input int limit, output int done_k);
    @(negedge clk);
    cmd_at_mode = at; cmd_opcode = op; cmd_len = len; cmd_payload = pl; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_at_mode = ~at; cmd_opcode = ~op; cmd_len = ~len; cmd_payload = ~pl;
    done_k = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      sample(k);
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (wireless_rx !== 1'b1)  begin bad++; $display("FAIL reset_rx: got %b want 1", wireless_rx); end
    total++; if (wireless_set !== 1'b1) begin bad++; $display("FAIL reset_set: got %b want 1", wireless_set); end
    total++; if (cmd_ready !== 1'b1)    begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)         begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_framed;
    int dk, got, nlow;
    logic [7:0] exp_b [0:5];
    exp_b = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h9E};
    run_cmd(1'b0, 8'h12, 3'd2, 32'h0000_5634, 1000, dk);
    total++; if (dk !== 601) begin bad++; $display("FAIL framed_done: got %0d want 601", dk); end
    total++; if (busy_log[1] !== 1'b1 || rdy_log[1] !== 1'b0)
      begin bad++; $display("FAIL framed_busy_start: got busy=%b rdy=%b want 1/0", busy_log[1], rdy_log[1]); end
    for (int b = 0; b < 6; b++) begin
      got = decode_byte(1 + b*100);
      total++; if (got !== int'(exp_b[b])) begin bad++; $display("FAIL framed_byte%0d: got %0d want %0d", b, got, exp_b[b]); end
    end
    nlow = 0;
    for (int k = 1; k <= 601; k++) if (set_log[k] !== 1'b1) nlow++;
    total++; if (nlow !== 0) begin bad++; $display("FAIL framed_set: got %0d low cycles want 0", nlow); end
    total++; if (busy_log[601] !== 1'b0 || rdy_log[601] !== 1'b1 || rx_log[601] !== 1'b1)
      begin bad++; $display("FAIL framed_done_cycle: got busy=%b rdy=%b rx=%b want 0/1/1", busy_log[601], rdy_log[601], rx_log[601]); end
  endtask

  task automatic test_at_mode;
    int dk, got, nlow, nrx;
    run_cmd(1'b1, 8'h00, 3'd2, 32'h0000_5441, 1000, dk);
    total++; if (dk !== 251) begin bad++; $display("FAIL at_done: got %0d want 251", dk); end
    total++; if (set_log[1] !== 1'b0) begin bad++; $display("FAIL at_set_fall: got %b want 0", set_log[1]); end
    nlow = 0;
    for (int k = 1; k <= 251; k++) if (set_log[k] === 1'b0) nlow++;
    total++; if (nlow !== 250) begin bad++; $display("FAIL at_set_low: got %0d want 250", nlow); end
    total++; if (set_log[251] !== 1'b1) begin bad++; $display("FAIL at_set_rise: got %b want 1", set_log[251]); end
    nrx = 0;
    for (int k = 1; k <= 20; k++) if (rx_log[k] !== 1'b1) nrx++;
    total++; if (nrx !== 0 || rx_log[21] !== 1'b0)
      begin bad++; $display("FAIL at_first_start: got early_low=%0d rx21=%b want 0/0", nrx, rx_log[21]); end
    got = decode_byte(21);
    total++; if (got !== 32'h41) begin bad++; $display("FAIL at_byte0: got %0d want 65", got); end
    got = decode_byte(121);
    total++; if (got !== 32'h54) begin bad++; $display("FAIL at_byte1: got %0d want 84", got); end
  endtask

  task automatic test_at_empty;
    int dk, nlow, nrx;
    run_cmd(1'b1, 8'h00, 3'd0, 32'h0, 1000, dk);
    total++; if (dk !== 51) begin bad++; $display("FAIL at0_done: got %0d want 51", dk); end
    nlow = 0; nrx = 0;
    for (int k = 1; k <= 51; k++) begin
      if (set_log[k] === 1'b0) nlow++;
      if (rx_log[k] !== 1'b1) nrx++;
    end
    total++; if (nlow !== 50) begin bad++; $display("FAIL at0_set_low: got %0d want 50", nlow); end
    total++; if (nrx !== 0) begin bad++; $display("FAIL at0_line: got %0d low cycles want 0", nrx); end
  endtask

  task automatic test_clamp;
    int dk, got;
    logic [7:0] exp_b [0:7];
    // len 7 clamps to 4; checksum 01+04+01+02+03+04 = 0F
    exp_b = '{8'hA5, 8'h01, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0F};
    run_cmd(1'b0, 8'h01, 3'd7, 32'h0403_0201, 1200, dk);
    total++; if (dk !== 801) begin bad++; $display("FAIL clamp_done: got %0d want 801", dk); end
    for (int b = 0; b < 8; b++) begin
      got = decode_byte(1 + b*100);
      total++; if (got !== int'(exp_b[b])) begin bad++; $display("FAIL clamp_byte%0d: got %0d want %0d", b, got, exp_b[b]); end
    end
  endtask

  task automatic test_checksum_wrap;
    int dk, got;
    logic [7:0] exp_b [0:7];
    // 0xFF + 0x04 + 4*0xFF = 0x4FF, mod 256 -> 0xFF
    exp_b = '{8'hA5, 8'hFF, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd(1'b0, 8'hFF, 3'd4, 32'hFFFF_FFFF, 1200, dk);
    total++; if (dk !== 801) begin bad++; $display("FAIL ff_done: got %0d want 801", dk); end
    for (int b = 0; b < 8; b++) begin
      got = decode_byte(1 + b*100);
      total++; if (got !== int'(exp_b[b])) begin bad++; $display("FAIL ff_byte%0d: got %0d want %0d", b, got, exp_b[b]); end
    end
  endtask

  task automatic test_back_to_back;
    int dk1, dk2, got;
    logic [7:0] exp1 [0:3];
    logic [7:0] exp2 [0:4];
    exp1 = '{8'hA5, 8'h77, 8'h00, 8'h77};
    exp2 = '{8'hA5, 8'h5A, 8'h01, 8'hC3, 8'h1E};
    @(negedge clk);
    cmd_at_mode = 1'b0; cmd_opcode = 8'h77; cmd_len = 3'd0; cmd_payload = 32'h0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_opcode = 8'h5A; cmd_len = 3'd1; cmd_payload = 32'h0000_00C3;
    dk1 = -1; dk2 = -1;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      sample(k);
      if (done) begin
        if (dk1 < 0) begin
          dk1 = k;
          @(posedge clk);
          #1;
          cmd_valid = 1'b0;
        end else begin
          dk2 = k;
          break;
        end
      end
    end
    cmd_valid = 1'b0;
    total++; if (dk1 !== 401) begin bad++; $display("FAIL b2b_done1: got %0d want 401", dk1); end
    total++; if (rdy_log[401] !== 1'b1 || busy_log[401] !== 1'b0)
      begin bad++; $display("FAIL b2b_done_cycle: got rdy=%b busy=%b want 1/0", rdy_log[401], busy_log[401]); end
    total++; if (rx_log[401] !== 1'b1 || rx_log[402] !== 1'b0 || busy_log[402] !== 1'b1)
      begin bad++; $display("FAIL b2b_restart: got rx401=%b rx402=%b busy402=%b want 1/0/1", rx_log[401], rx_log[402], busy_log[402]); end
    total++; if (dk2 !== 902) begin bad++; $display("FAIL b2b_done2: got %0d want 902", dk2); end
    for (int b = 0; b < 4; b++) begin
      got = decode_byte(1 + b*100);
      total++; if (got !== int'(exp1[b])) begin bad++; $display("FAIL b2b_first_byte%0d: got %0d want %0d", b, got, exp1[b]); end
    end
    for (int b = 0; b < 5; b++) begin
      got = decode_byte(402 + b*100);
      total++; if (got !== int'(exp2[b])) begin bad++; $display("FAIL b2b_second_byte%0d: got %0d want %0d", b, got, exp2[b]); end
    end
  endtask

  task automatic test_reset_mid;
    int ndone, nlow;
    @(negedge clk);
    cmd_at_mode = 1'b0; cmd_opcode = 8'h12; cmd_len = 3'd2; cmd_payload = 32'h0000_5634; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      sample(k);
    end
    total++; if (rx_log[105] !== 1'b0) begin bad++; $display("FAIL rstmid_pre_rx: got %b want 0", rx_log[105]); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (wireless_rx !== 1'b1 || wireless_set !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL rstmid_abort: got rx=%b set=%b rdy=%b busy=%b done=%b want 1/1/1/0/0",
                            wireless_rx, wireless_set, cmd_ready, busy, done); end
    rst = 1'b0;
    ndone = 0; nlow = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (wireless_rx !== 1'b1) nlow++;
    end
    total++; if (ndone !== 0 || nlow !== 0)
      begin bad++; $display("FAIL rstmid_quiet: got done=%0d rx_low=%0d want 0/0", ndone, nlow); end

    @(negedge clk);
    cmd_at_mode = 1'b1; cmd_len = 3'd2; cmd_payload = 32'h0000_5441; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (wireless_set !== 1'b0) begin bad++; $display("FAIL rstmid_at_pre_set: got %b want 0", wireless_set); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (wireless_set !== 1'b1 || cmd_ready !== 1'b1)
      begin bad++; $display("FAIL rstmid_at_abort: got set=%b rdy=%b want 1/1", wireless_set, cmd_ready); end
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1 || wireless_set !== 1'b1) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_at_quiet: got %0d bad cycles want 0", ndone); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_at_mode = 1'b0;
    cmd_opcode = '0; cmd_len = '0; cmd_payload = '0;
    test_reset;
    test_framed;
    test_at_mode;
    test_at_empty;
    test_clamp;
    test_checksum_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
